// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register. It decodes ALU control from the same input cycle as the operands
// and registers it alongside them. It also applies stall/flush hazard control and counts bubbles.
module idex_pipe_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   iimm_i,
    input  logic [XLEN-1:0]   simm_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [1:0]        alu_op_i,
    input  logic              alu_src_i,
    input  logic [1:0]        mem_i,
    input  logic              wb_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   val1_o,
    output logic [XLEN-1:0]   val2_o,
    output logic [XLEN-1:0]   simm_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [1:0]        mem_o,
    output logic              wb_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   val1_q, val1_d;
    logic [XLEN-1:0]   val2_q, val2_d;
    logic [XLEN-1:0]   simm_q, simm_d;
    logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [1:0]        mem_q, mem_d;
    logic              wb_q, wb_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic [3:0]        dec_ctrl;
    logic              dec_illegal;
    logic [9:0]        funct;
    logic              bubble_evt;

    assign funct = {funct7_i, funct3_i};

    always_comb begin
        dec_ctrl    = 4'b0010;
        dec_illegal = 1'b0;
        unique case (alu_op_i)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b10: begin
                case (funct)
                    10'b0000000_000: dec_ctrl = 4'b0010;
                    10'b0100000_000: dec_ctrl = 4'b0110;
                    10'b0000000_111: dec_ctrl = 4'b0000;
                    10'b0000000_110: dec_ctrl = 4'b0001;
                    10'b0000000_100: dec_ctrl = 4'b0011;
                    10'b0000000_001: dec_ctrl = 4'b0100;
                    10'b0000001_000: dec_ctrl = 4'b1111;
                    default:         dec_illegal = 1'b1;
                endcase
            end
            2'b11: begin
                if (funct3_i == 3'b000) begin
                    dec_ctrl = 4'b0010;
                end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
                    dec_ctrl = 4'b1000;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_ctrl = 4'b0010;
        endcase
    end

    // Flush wins over stall, so a flushed stall cycle also counts as a bubble.
    assign bubble_evt = flush_i | (~stall_i & ~valid_i);

    always_comb begin
        valid_d    = valid_q;
        val1_d     = val1_q;
        val2_d     = val2_q;
        simm_d     = simm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        alu_ctrl_d = alu_ctrl_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        illegal_d  = illegal_q;
        if (flush_i) begin
            valid_d    = 1'b0;
            val1_d     = '0;
            val2_d     = '0;
            simm_d     = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            alu_ctrl_d = '0;
            mem_d      = '0;
            wb_d       = 1'b0;
            illegal_d  = 1'b0;
        end else if (!stall_i) begin
            valid_d    = valid_i;
            val1_d     = rs1_data_i;
            val2_d     = alu_src_i ? iimm_i : rs2_data_i;
            simm_d     = simm_i;
            rs1_addr_d = rs1_addr_i;
            rs2_addr_d = rs2_addr_i;
            rd_addr_d  = rd_addr_i;
            alu_ctrl_d = dec_ctrl;
            mem_d      = valid_i ? mem_i : 2'b00;
            wb_d       = valid_i & wb_i;
            illegal_d  = valid_i & dec_illegal;
        end

        bubble_cnt_d = bubble_cnt_q;
        if (bubble_evt && bubble_cnt_q != {CNT_W{1'b1}}) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            val1_q       <= '0;
            val2_q       <= '0;
            simm_q       <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            alu_ctrl_q   <= '0;
            mem_q        <= '0;
            wb_q         <= 1'b0;
            illegal_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            val1_q       <= val1_d;
            val2_q       <= val2_d;
            simm_q       <= simm_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_addr_q    <= rd_addr_d;
            alu_ctrl_q   <= alu_ctrl_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            illegal_q    <= illegal_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign val1_o       = val1_q;
    assign val2_o       = val2_q;
    assign simm_o       = simm_q;
    assign rs1_addr_o   = rs1_addr_q;
    assign rs2_addr_o   = rs2_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign mem_o        = mem_q;
    assign wb_o         = wb_q;
    assign illegal_o    = illegal_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule
